// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_stream_reader_pkg;

    localparam int PACKET_COUNT_WIDTH = 32;

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } state_e;

    // FIFO words carry the last flag directly above the payload bits.
    function automatic int LAST_BIT(input int dataWidth);
        return dataWidth;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buffer.sv
// Small synchronous show-ahead FIFO that absorbs the read latency of the CDC FIFO.
module fifo_stream_reader_buffer
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         headData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush, doPop;

    // A push while full is still taken when the same cycle pops an entry.
    always_comb begin
        doPop   = pop_i && (count_q != '0);
        doPush  = push_i && ((count_q != DEPTH_COUNT) || doPop);
        wrPtr_d = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = doPop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign headData_o  = mem_q[rdPtr_q];
    assign full_o      = (count_q == DEPTH_COUNT);
    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer of the CDC FIFO: credit-controlled reads, buffered
// valid/ready stream with packet length policing and packet counting.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH        = 16,
    parameter int READ_LATENCY      = 1,
    parameter int BUFFER_DEPTH      = 4,
    parameter int MAX_PACKET_LENGTH = 1522
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH:0]           fifo_read_data,
    input  logic                          fifo_read_data_valid,
    output logic                          fifo_read_enable,
    output logic [DATA_WIDTH-1:0]         stream_data,
    output logic                          stream_last,
    output logic                          stream_valid,
    input  logic                          stream_ready,
    output logic [PACKET_COUNT_WIDTH-1:0] packet_count,
    output logic                          oversize_error
);

    localparam int CNT_W    = $clog2(BUFFER_DEPTH) + 1;
    localparam int LAST_IDX = LAST_BIT(DATA_WIDTH);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(BUFFER_DEPTH);
    localparam logic [15:0]    FINAL_INDEX  = 16'(MAX_PACKET_LENGTH - 1);
    localparam logic [1:0]     DRAIN_CYCLES = 2'(READ_LATENCY);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              inFlight_q, inFlight_d;
    logic [1:0]                    drain_q, drain_d;
    logic [15:0]                   length_q, length_d;
    logic [PACKET_COUNT_WIDTH-1:0] packetCount_q, packetCount_d;
    logic                          oversize_q, oversize_d;

    logic                          bufPush, bufPop, bufFull, bufEmpty;
    logic [CNT_W-1:0]              bufOccupancy;
    logic [DATA_WIDTH:0]           bufHead;
    logic                          headLast, forceLast, beatTaken, returnCounted;

    fifo_stream_reader_buffer #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (BUFFER_DEPTH)
    ) bufferInst (
        .clock_i     (clock),
        .reset_i     (reset),
        .push_i      (bufPush),
        .pushData_i  (fifo_read_data),
        .pop_i       (bufPop),
        .headData_o  (bufHead),
        .full_o      (bufFull),
        .empty_o     (bufEmpty),
        .occupancy_o (bufOccupancy)
    );

    // Returns of reads issued before a reset are ignored while the drain counter runs.
    assign bufPush       = fifo_read_data_valid && (drain_q == 2'd0);
    assign returnCounted = bufPush && (inFlight_q != '0);

    assign fifo_read_enable = !fifo_empty && !bufFull && !reset &&
        (({1'b0, bufOccupancy} + {1'b0, inFlight_q}) < CREDIT_LIMIT);

    always_comb begin
        inFlight_d = inFlight_q;
        if (fifo_read_enable && !returnCounted) begin
            inFlight_d = inFlight_q + CNT_W'(1);
        end else if (!fifo_read_enable && returnCounted) begin
            inFlight_d = inFlight_q - CNT_W'(1);
        end
        drain_d = (drain_q != 2'd0) ? drain_q - 2'd1 : 2'd0;
    end

    // The beat at index MAX_PACKET_LENGTH-1 without a natural last closes the
    // packet early; the rest of the frame is then dropped in DISCARD.
    always_comb begin
        state_d       = state_q;
        length_d      = length_q;
        packetCount_d = packetCount_q;
        oversize_d    = 1'b0;
        bufPop        = 1'b0;
        stream_valid  = 1'b0;
        stream_last   = 1'b0;
        stream_data   = '0;
        headLast      = bufHead[LAST_IDX];
        forceLast     = (length_q == FINAL_INDEX) && !headLast;
        beatTaken     = 1'b0;

        unique case (state_q)
            PASS: begin
                if (!bufEmpty) begin
                    stream_valid = 1'b1;
                    stream_data  = bufHead[DATA_WIDTH-1:0];
                    stream_last  = headLast || forceLast;
                end
                beatTaken = stream_valid && stream_ready;
                if (beatTaken) begin
                    bufPop = 1'b1;
                    if (stream_last) begin
                        packetCount_d = packetCount_q + PACKET_COUNT_WIDTH'(1);
                        length_d      = '0;
                        if (forceLast) begin
                            oversize_d = 1'b1;
                            state_d    = DISCARD;
                        end
                    end else begin
                        length_d = length_q + 16'd1;
                    end
                end
            end
            DISCARD: begin
                if (!bufEmpty) begin
                    bufPop = 1'b1;
                    if (headLast) begin
                        state_d = PASS;
                    end
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= PASS;
            inFlight_q    <= '0;
            drain_q       <= DRAIN_CYCLES;
            length_q      <= '0;
            packetCount_q <= '0;
            oversize_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            inFlight_q    <= inFlight_d;
            drain_q       <= drain_d;
            length_q      <= length_d;
            packetCount_q <= packetCount_d;
            oversize_q    <= oversize_d;
        end
    end

    assign packet_count   = packetCount_q;
    assign oversize_error = oversize_q;

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side consumer of the switch's clock-domain-crossing FIFO: issues `fifo_read_enable`, absorbs the FIFO's fixed read latency in a small credit-controlled buffer, and presents packets as a valid/ready stream with `last` framing in the read clock domain. It also enforces a maximum packet length, truncating and discarding oversize frames, and keeps a running count of forwarded packets for the port statistics block.

## Interface
- `DATA_WIDTH`, 16: payload width; FIFO word is `DATA_WIDTH+1` bits, MSB = last flag.
- `READ_LATENCY`, 1: cycles from `fifo_read_enable` to `fifo_read_data_valid`; 1 = unpipelined memory, 2 = pipelined; legal 1..2.
- `BUFFER_DEPTH`, 4: internal buffer entries; power of two, ≥ `READ_LATENCY`+2.
- `MAX_PACKET_LENGTH`, 1522: maximum beats per packet; ≥ 2.
- `clock`  in  1  sole clock (the FIFO read clock).
- `reset`  in  1  synchronous, active-high reset; one clock, no other clock domains.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  `DATA_WIDTH+1`  FIFO word, `[DATA_WIDTH]` = last.
- `fifo_read_data_valid`  in  1  `fifo_read_data` valid this cycle.
- `fifo_read_enable`  out  1  FIFO read request.
- `stream_data`  out  `DATA_WIDTH`  payload beat.
- `stream_last`  out  1  final beat of packet.
- `stream_valid`  out  1  beat available.
- `stream_ready`  in  1  downstream accepts beat.
- `packet_count`  out  32  packets forwarded, wraps at 2^32.
- `oversize_error`  out  1  one-cycle pulse on truncation.

## Operation
- Credit rule: `fifo_read_enable` = `!fifo_empty && (occupancy + in_flight) < BUFFER_DEPTH && !reset`; combinational from registered state.
- `in_flight` (width `$clog2(BUFFER_DEPTH)+1`): +1 on read issue, −1 on `fifo_read_data_valid`; both in one cycle → unchanged; never below 0 (valid without outstanding read is still stored if room, counter held at 0).
- Every `fifo_read_data_valid` word is written to the buffer; the credit rule guarantees room. A write when full is dropped.
- States: `PASS` (reset) and `DISCARD`.
- `PASS`: head word drives `stream_*`; beat consumed when `stream_valid && stream_ready`. `length` counter (16 bits) +1 per consumed beat, cleared on consumed last.
- Truncation: in `PASS`, if head is the `MAX_PACKET_LENGTH`-th beat and its last flag is 0, `stream_last` forced 1. On its consumption: `oversize_error` pulses, `packet_count` +1, `length` cleared, → `DISCARD`.
- `DISCARD`: `stream_valid` = 0; one buffer word popped per cycle regardless of `stream_ready`; popping a word with last flag = 1 → `PASS`. Reads from FIFO continue.
- `packet_count` +1 on each consumed beat with `stream_last` = 1 (natural or forced).
- A packet of exactly `MAX_PACKET_LENGTH` beats with natural last is forwarded unmodified, no error.

## Timing
- Reset values: `fifo_read_enable` 0, `stream_valid` 0, `stream_last` 0, `stream_data` 0, `packet_count` 0, `oversize_error` 0; buffer emptied, `in_flight` 0, `length` 0, state `PASS`.
- `reset` asserted mid-packet: all state cleared next edge; in-flight FIFO returns arriving during/after reset are discarded for `READ_LATENCY` cycles after deassert (drain counter); partial packet lost, no `last` emitted.
- Latency: `fifo_read_data_valid` at edge N → `stream_valid` high after edge N+1 (buffer is show-ahead, output registered at buffer).
- Throughput: one beat per cycle sustained with `stream_ready` held high and FIFO non-empty.
- `stream_data`/`stream_last` stable while `stream_valid && !stream_ready`; `stream_valid` never drops without acceptance.
- Simultaneous buffer push and pop: occupancy unchanged, legal at full and empty (pop at empty not possible; push when empty passes through next cycle).

## Structure
- Package `fifo_stream_reader_pkg`: state enum (`PASS`, `DISCARD`), `LAST_BIT` index function of `DATA_WIDTH`, `PACKET_COUNT_WIDTH` = 32.
- One sub-module `fifo_stream_reader_buffer`: synchronous show-ahead FIFO, `BUFFER_DEPTH` × `DATA_WIDTH+1`, push/pop/full/empty/occupancy, synchronous active-high reset.
- Credit logic, state machine, length and packet counters in the top module.

## Test plan
- Reset then 4-beat packet 0x0001..0x0004 (last on 4th), `stream_ready`=1, `READ_LATENCY`=1 → beats in order, `stream_last` on 0x0004 only, `packet_count`=1, continuous valid.
- Same with `READ_LATENCY`=2, 64 back-to-back 8-beat packets → 512 beats, no gaps after fill, `packet_count`=64, buffer never overflows.
- `stream_ready` toggled 1-0 random 50% → data stable while stalled, no loss/duplication, `in_flight+occupancy` ≤ `BUFFER_DEPTH` always.
- `MAX_PACKET_LENGTH`=4, 7-beat packet then 2-beat packet → beats 1–4 forwarded with forced last on beat 4, `oversize_error` one pulse, beats 5–7 dropped, 2-beat packet follows intact, `packet_count`=2.
- Exactly 4-beat packet at `MAX_PACKET_LENGTH`=4 → forwarded, no `oversize_error`.
- `reset` asserted for 1 cycle mid-packet with 2 reads in flight → outputs at reset values next cycle, in-flight returns discarded, next full packet forwarded correctly, `packet_count` counts from 0.
